// File: rtl/scalar_dispatch_pkg.sv
// Shared types for the scalar dispatch stage: FU identifiers, tag encoding and FSM states.
package scalar_dispatch_pkg;

  typedef enum logic [1:0] {
    FU_ALU    = 2'd0,
    FU_LDST   = 2'd1,
    FU_BRANCH = 2'd2
  } fu_scalar_t;

  localparam int SCALAR_TAG_W = 2;
  typedef logic [SCALAR_TAG_W-1:0] scalar_tag_t;
  localparam scalar_tag_t TAG_READY = '0;

  typedef enum logic {
    RUN     = 1'b0,
    BR_WAIT = 1'b1
  } dispatch_state_e;

  // Encoding 3 has no FU behind it; route it to the ALU.
  function automatic fu_scalar_t fu_decode(input logic [1:0] raw);
    return (raw == 2'd3) ? FU_ALU : fu_scalar_t'(raw);
  endfunction

  function automatic scalar_tag_t fu_tag(input fu_scalar_t fu);
    return scalar_tag_t'(fu) + scalar_tag_t'(1);
  endfunction

endpackage

// File: rtl/scalar_dispatch_rst.sv
// Register Status Table: producer tag per architectural register, two source reads,
// a destination probe, one set port and a broadcast clear by tag. Bypass: SCALAR_DISPATCH_WB_BYPASS_EN.
module scalar_dispatch_rst
  import scalar_dispatch_pkg::*;
#(
  parameter int NREGS = 32,
  parameter int TAG_W = 2
) (
  input  logic                     CLK,
  input  logic                     nRST,
  input  logic [$clog2(NREGS)-1:0] rs1_addr,
  input  logic [$clog2(NREGS)-1:0] rs2_addr,
  input  logic [$clog2(NREGS)-1:0] rd_addr,
  output logic [TAG_W-1:0]         rs1_tag,
  output logic [TAG_W-1:0]         rs2_tag,
  output logic [TAG_W-1:0]         rd_tag,
  input  logic                     set_en,
  input  logic [$clog2(NREGS)-1:0] set_addr,
  input  logic [TAG_W-1:0]         set_tag,
  input  logic                     wb_valid,
  input  logic [TAG_W-1:0]         wb_tag
);

  localparam int AW = $clog2(NREGS);

  logic [TAG_W-1:0] rst_q [NREGS];

  function automatic logic [TAG_W-1:0] read_tag(input logic [AW-1:0] a);
    logic [TAG_W-1:0] t;
    t = (a == '0) ? TAG_READY : rst_q[a];
`ifdef SCALAR_DISPATCH_WB_BYPASS_EN
    if (wb_valid && t == wb_tag) t = TAG_READY;
`endif
    return t;
  endfunction

  always_comb begin
    rs1_tag = read_tag(rs1_addr);
    rs2_tag = read_tag(rs2_addr);
    rd_tag  = read_tag(rd_addr);
  end

  // x0 is never written; a new producer overrides a same-cycle clear of its entry.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < NREGS; i++) rst_q[i] <= '0;
    end else begin
      for (int i = 1; i < NREGS; i++) begin
        if (set_en && set_addr == AW'(i))
          rst_q[i] <= set_tag;
        else if (wb_valid && rst_q[i] == wb_tag)
          rst_q[i] <= TAG_READY;
      end
    end
  end

endmodule

// File: rtl/scalar_dispatch.sv
// Scalar dispatch stage: one-entry D-reg, RST hazard tracking, branch wait and flush.
// Optional same-cycle writeback forwarding: SCALAR_DISPATCH_WB_BYPASS_EN.
module scalar_dispatch
  import scalar_dispatch_pkg::*;
#(
  parameter int NREGS = 32,
  parameter int NFU_S = 3,
  parameter int TAG_W = 2
) (
  input  logic                   CLK,
  input  logic                   nRST,
  input  logic                   fetch_valid,
  output logic                   fetch_ready,
  input  logic [1:0]             fetch_fu,
  input  logic [4:0]             fetch_rd,
  input  logic [4:0]             fetch_rs1,
  input  logic [4:0]             fetch_rs2,
  input  logic                   fetch_wen,
  input  logic [31:0]            fetch_imm,
  input  logic [NFU_S-1:0]       fust_busy,
  input  logic                   freeze,
  input  logic                   wb_valid,
  input  logic [TAG_W-1:0]       wb_tag,
  input  logic                   branch_resolved,
  input  logic                   branch_miss,
  output logic                   n_fust_s_en,
  output logic [1:0]             n_fu_s,
  output logic [4:0]             n_rd,
  output logic [4:0]             n_rs1,
  output logic [4:0]             n_rs2,
  output logic [31:0]            n_imm,
  output logic [NFU_S*TAG_W-1:0] n_t1,
  output logic [NFU_S*TAG_W-1:0] n_t2,
  output logic                   br_pending
);

  dispatch_state_e state_q;
  logic            d_valid_q;
  fu_scalar_t      d_fu_q;
  logic [4:0]      d_rd_q;
  logic [4:0]      d_rs1_q;
  logic [4:0]      d_rs2_q;
  logic            d_wen_q;
  logic [31:0]     d_imm_q;

  logic [1:0]       fu_idx;
  logic [TAG_W-1:0] tag_rs1;
  logic [TAG_W-1:0] tag_rs2;
  logic [TAG_W-1:0] tag_rd;
  logic             waw;
  logic             fire;
  logic             flush;
  logic             load;
  logic             set_en;

  assign fu_idx = d_fu_q;
  assign waw    = d_wen_q && (d_rd_q != 5'd0) && (tag_rd != TAG_READY);
  assign fire   = d_valid_q && (state_q == RUN) && !freeze && !fust_busy[fu_idx] && !waw;
  assign flush  = (state_q == BR_WAIT) && branch_resolved && branch_miss;
  assign set_en = fire && d_wen_q && (d_rd_q != 5'd0);

  always_comb begin
    fetch_ready = 1'b0;
    if (flush)
      fetch_ready = 1'b0;
    else if (state_q == BR_WAIT)
      fetch_ready = !d_valid_q;
    else
      fetch_ready = !d_valid_q || fire;
  end

  assign load = fetch_valid && fetch_ready;

  scalar_dispatch_rst #(
    .NREGS (NREGS),
    .TAG_W (TAG_W)
  ) u_rst (
    .CLK      (CLK),
    .nRST     (nRST),
    .rs1_addr (d_rs1_q),
    .rs2_addr (d_rs2_q),
    .rd_addr  (d_rd_q),
    .rs1_tag  (tag_rs1),
    .rs2_tag  (tag_rs2),
    .rd_tag   (tag_rd),
    .set_en   (set_en),
    .set_addr (d_rd_q),
    .set_tag  (fu_tag(d_fu_q)),
    .wb_valid (wb_valid),
    .wb_tag   (wb_tag)
  );

  // Branch resolution is an event, so it is taken even while frozen.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q   <= RUN;
      d_valid_q <= 1'b0;
    end else begin
      case (state_q)
        RUN:     if (fire && d_fu_q == FU_BRANCH) state_q <= BR_WAIT;
        BR_WAIT: if (branch_resolved) state_q <= RUN;
        default: state_q <= RUN;
      endcase
      if (flush)
        d_valid_q <= 1'b0;
      else if (load)
        d_valid_q <= 1'b1;
      else if (fire)
        d_valid_q <= 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (load) begin
      d_fu_q  <= fu_decode(fetch_fu);
      d_rd_q  <= fetch_rd;
      d_rs1_q <= fetch_rs1;
      d_rs2_q <= fetch_rs2;
      d_wen_q <= fetch_wen;
      d_imm_q <= fetch_imm;
    end
  end

  // Issue-side row write: combinational from the D-reg, zeroed unless firing.
  always_comb begin
    n_fust_s_en = fire;
    n_fu_s      = '0;
    n_rd        = '0;
    n_rs1       = '0;
    n_rs2       = '0;
    n_imm       = '0;
    n_t1        = '0;
    n_t2        = '0;
    if (fire) begin
      n_fu_s = fu_idx;
      n_rd   = d_rd_q;
      n_rs1  = d_rs1_q;
      n_rs2  = d_rs2_q;
      n_imm  = d_imm_q;
      n_t1[int'(fu_idx)*TAG_W +: TAG_W] = tag_rs1;
      n_t2[int'(fu_idx)*TAG_W +: TAG_W] = tag_rs2;
    end
  end

  assign br_pending = (state_q == BR_WAIT);

endmodule

// File: tb/tb_scalar_dispatch.sv
// Directed bench for scalar_dispatch: per-cycle handshake checks plus a scoreboard of issued rows.
module tb_scalar_dispatch;

  logic        CLK;
  logic        nRST;
  logic        fetch_valid;
  logic        fetch_ready;
  logic [1:0]  fetch_fu;
  logic [4:0]  fetch_rd, fetch_rs1, fetch_rs2;
  logic        fetch_wen;
  logic [31:0] fetch_imm;
  logic [2:0]  fust_busy;
  logic        freeze;
  logic        wb_valid;
  logic [1:0]  wb_tag;
  logic        branch_resolved, branch_miss;
  logic        n_fust_s_en;
  logic [1:0]  n_fu_s;
  logic [4:0]  n_rd, n_rs1, n_rs2;
  logic [31:0] n_imm;
  logic [5:0]  n_t1, n_t2;
  logic        br_pending;

  int checks = 0;
  int errors = 0;
  logic [63:0] sb [$];

  scalar_dispatch dut (
    .CLK(CLK), .nRST(nRST),
    .fetch_valid(fetch_valid), .fetch_ready(fetch_ready),
    .fetch_fu(fetch_fu), .fetch_rd(fetch_rd), .fetch_rs1(fetch_rs1),
    .fetch_rs2(fetch_rs2), .fetch_wen(fetch_wen), .fetch_imm(fetch_imm),
    .fust_busy(fust_busy), .freeze(freeze),
    .wb_valid(wb_valid), .wb_tag(wb_tag),
    .branch_resolved(branch_resolved), .branch_miss(branch_miss),
    .n_fust_s_en(n_fust_s_en), .n_fu_s(n_fu_s), .n_rd(n_rd),
    .n_rs1(n_rs1), .n_rs2(n_rs2), .n_imm(n_imm),
    .n_t1(n_t1), .n_t2(n_t2), .br_pending(br_pending)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] exp_row(input logic [1:0] fu, input logic [4:0] rd,
      input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm,
      input logic [1:0] t1, input logic [1:0] t2);
    logic [5:0] p1, p2;
    p1 = '0;
    p2 = '0;
    p1[int'(fu)*2 +: 2] = t1;
    p2[int'(fu)*2 +: 2] = t2;
    return {3'b0, fu, rd, rs1, rs2, imm, p1, p2};
  endfunction

  task automatic offer(input logic [1:0] fu, input logic [4:0] rd, input logic [4:0] rs1,
      input logic [4:0] rs2, input logic wen, input logic [31:0] imm);
    fetch_valid = 1'b1;
    fetch_fu    = fu;
    fetch_rd    = rd;
    fetch_rs1   = rs1;
    fetch_rs2   = rs2;
    fetch_wen   = wen;
    fetch_imm   = imm;
  endtask

  // Sample at the falling edge, then return just after the next rising edge.
  task automatic cyc(input string tag, input logic en, input logic rdy, input logic bp);
    @(negedge CLK);
    chk({tag, "_en"}, n_fust_s_en, en);
    chk({tag, "_rdy"}, fetch_ready, rdy);
    chk({tag, "_bp"}, br_pending, bp);
    @(posedge CLK);
    #1;
  endtask

  always @(negedge CLK) begin
    if (nRST === 1'b1 && n_fust_s_en === 1'b1) begin
      checks++;
      assert (sb.size() > 0) else begin
        errors++;
        $error("FAIL sb_fire observed=unexpected_fire expected=queued_row");
      end
      if (sb.size() > 0)
        chk("sb_row", {3'b0, n_fu_s, n_rd, n_rs1, n_rs2, n_imm, n_t1, n_t2}, sb.pop_front());
    end
  end

  initial begin
    nRST = 1'b1;
    fetch_valid = 0; fetch_fu = 0; fetch_rd = 0; fetch_rs1 = 0; fetch_rs2 = 0;
    fetch_wen = 0; fetch_imm = 0; fust_busy = 0; freeze = 0;
    wb_valid = 0; wb_tag = 0; branch_resolved = 0; branch_miss = 0;
    #2 nRST = 1'b0;
    #1;
    chk("rst_en", n_fust_s_en, 1'b0);
    chk("rst_rdy", fetch_ready, 1'b1);
    chk("rst_bp", br_pending, 1'b0);
    chk("rst_row", {n_fu_s, n_rd, n_rs1, n_rs2, n_imm, n_t1, n_t2}, 61'd0);
    @(posedge CLK); #1 nRST = 1'b1;

    // ADD x5 = x1 + x2 on the ALU
    offer(2'd0, 5'd5, 5'd1, 5'd2, 1'b1, 32'h11);
    sb.push_back(exp_row(2'd0, 5'd5, 5'd1, 5'd2, 32'h11, 2'd0, 2'd0));
    cyc("s1_acc", 1'b0, 1'b1, 1'b0);
    fetch_valid = 1'b0;
    cyc("s1_fire", 1'b1, 1'b1, 1'b0);
    chk("s1_rst5", dut.u_rst.rst_q[5], 2'd1);
    wb_valid = 1'b1; wb_tag = 2'd1;
    cyc("s1_wb", 1'b0, 1'b1, 1'b0);
    wb_valid = 1'b0;
    chk("s1_rst5_clr", dut.u_rst.rst_q[5], 2'd0);

    // LD x5 then dependent ADD x6 = x5 + x2
    offer(2'd1, 5'd5, 5'd0, 5'd0, 1'b1, 32'h20);
    sb.push_back(exp_row(2'd1, 5'd5, 5'd0, 5'd0, 32'h20, 2'd0, 2'd0));
    cyc("s2_ld_acc", 1'b0, 1'b1, 1'b0);
    offer(2'd0, 5'd6, 5'd5, 5'd2, 1'b1, 32'h21);
    sb.push_back(exp_row(2'd0, 5'd6, 5'd5, 5'd2, 32'h21, 2'd2, 2'd0));
    cyc("s2_ld_fire", 1'b1, 1'b1, 1'b0);
    fetch_valid = 1'b0;
    cyc("s2_add_fire", 1'b1, 1'b1, 1'b0);
    chk("s2_rst5", dut.u_rst.rst_q[5], 2'd2);
    chk("s2_rst6", dut.u_rst.rst_q[6], 2'd1);
    wb_valid = 1'b1; wb_tag = 2'd2;
    cyc("s2_wb2", 1'b0, 1'b1, 1'b0);
    chk("s2_rst5_clr", dut.u_rst.rst_q[5], 2'd0);
    chk("s2_rst6_keep", dut.u_rst.rst_q[6], 2'd1);
    wb_tag = 2'd1;
    cyc("s2_wb1", 1'b0, 1'b1, 1'b0);
    wb_valid = 1'b0;
    chk("s2_rst6_clr", dut.u_rst.rst_q[6], 2'd0);

    // WAW on x7
    offer(2'd0, 5'd7, 5'd0, 5'd0, 1'b1, 32'h30);
    sb.push_back(exp_row(2'd0, 5'd7, 5'd0, 5'd0, 32'h30, 2'd0, 2'd0));
    cyc("s3_i1_acc", 1'b0, 1'b1, 1'b0);
    offer(2'd0, 5'd7, 5'd3, 5'd4, 1'b1, 32'h31);
    sb.push_back(exp_row(2'd0, 5'd7, 5'd3, 5'd4, 32'h31, 2'd0, 2'd0));
    cyc("s3_i1_fire", 1'b1, 1'b1, 1'b0);
    fetch_valid = 1'b0;
    cyc("s3_stall1", 1'b0, 1'b0, 1'b0);
    cyc("s3_stall2", 1'b0, 1'b0, 1'b0);
    wb_valid = 1'b1; wb_tag = 2'd1;
`ifdef SCALAR_DISPATCH_WB_BYPASS_EN
    cyc("s3_wb_fire", 1'b1, 1'b1, 1'b0);
    wb_valid = 1'b0;
`else
    cyc("s3_wb", 1'b0, 1'b0, 1'b0);
    wb_valid = 1'b0;
    cyc("s3_fire", 1'b1, 1'b1, 1'b0);
`endif
    chk("s3_rst7", dut.u_rst.rst_q[7], 2'd1);
    wb_valid = 1'b1; wb_tag = 2'd1;
    cyc("s3_clr", 1'b0, 1'b1, 1'b0);
    wb_valid = 1'b0;

    // Structural stall on a busy ALU, then a freeze with an empty D-reg
    fust_busy = 3'b001;
    offer(2'd3, 5'd8, 5'd1, 5'd1, 1'b1, 32'h40);
    sb.push_back(exp_row(2'd0, 5'd8, 5'd1, 5'd1, 32'h40, 2'd0, 2'd0));
    cyc("s4_acc", 1'b0, 1'b1, 1'b0);
    fetch_valid = 1'b0;
    cyc("s4_busy1", 1'b0, 1'b0, 1'b0);
    cyc("s4_busy2", 1'b0, 1'b0, 1'b0);
    fust_busy = 3'b000;
    cyc("s4_fire", 1'b1, 1'b1, 1'b0);
    freeze = 1'b1;
    offer(2'd0, 5'd12, 5'd0, 5'd0, 1'b1, 32'h41);
    sb.push_back(exp_row(2'd0, 5'd12, 5'd0, 5'd0, 32'h41, 2'd0, 2'd0));
    cyc("s4_frz_acc", 1'b0, 1'b1, 1'b0);
    fetch_valid = 1'b0;
    cyc("s4_frozen", 1'b0, 1'b0, 1'b0);
    freeze = 1'b0;
    cyc("s4_thaw_fire", 1'b1, 1'b1, 1'b0);
    wb_valid = 1'b1; wb_tag = 2'd1;
    cyc("s4_clr", 1'b0, 1'b1, 1'b0);
    wb_valid = 1'b0;
    chk("s4_rst8_clr", dut.u_rst.rst_q[8], 2'd0);
    chk("s4_rst12_clr", dut.u_rst.rst_q[12], 2'd0);

    // Mispredicted branch flushes the wrong-path instruction
    offer(2'd2, 5'd0, 5'd1, 5'd2, 1'b0, 32'h50);
    sb.push_back(exp_row(2'd2, 5'd0, 5'd1, 5'd2, 32'h50, 2'd0, 2'd0));
    cyc("s5_br_acc", 1'b0, 1'b1, 1'b0);
    offer(2'd0, 5'd9, 5'd0, 5'd0, 1'b1, 32'h51);
    cyc("s5_br_fire", 1'b1, 1'b1, 1'b0);
    fetch_valid = 1'b0;
    cyc("s5_wait", 1'b0, 1'b0, 1'b1);
    branch_resolved = 1'b1; branch_miss = 1'b1;
    cyc("s5_miss", 1'b0, 1'b0, 1'b1);
    branch_resolved = 1'b0; branch_miss = 1'b0;
    cyc("s5_flushed", 1'b0, 1'b1, 1'b0);
    chk("s5_rst9", dut.u_rst.rst_q[9], 2'd0);

    // Correctly predicted branch: held instruction issues after resolve
    offer(2'd2, 5'd0, 5'd3, 5'd4, 1'b0, 32'h60);
    sb.push_back(exp_row(2'd2, 5'd0, 5'd3, 5'd4, 32'h60, 2'd0, 2'd0));
    cyc("s6_br_acc", 1'b0, 1'b1, 1'b0);
    offer(2'd0, 5'd10, 5'd1, 5'd2, 1'b1, 32'h61);
    sb.push_back(exp_row(2'd0, 5'd10, 5'd1, 5'd2, 32'h61, 2'd0, 2'd0));
    cyc("s6_br_fire", 1'b1, 1'b1, 1'b0);
    fetch_valid = 1'b0;
    cyc("s6_wait", 1'b0, 1'b0, 1'b1);
    branch_resolved = 1'b1;
    cyc("s6_hit", 1'b0, 1'b0, 1'b1);
    branch_resolved = 1'b0;
    cyc("s6_fire", 1'b1, 1'b1, 1'b0);
    chk("s6_rst10", dut.u_rst.rst_q[10], 2'd1);

    // Set wins over a same-cycle clear of the same tag
    offer(2'd0, 5'd3, 5'd0, 5'd0, 1'b1, 32'h70);
    sb.push_back(exp_row(2'd0, 5'd3, 5'd0, 5'd0, 32'h70, 2'd0, 2'd0));
    cyc("s7_acc", 1'b0, 1'b1, 1'b0);
    fetch_valid = 1'b0;
    wb_valid = 1'b1; wb_tag = 2'd1;
    cyc("s7_fire", 1'b1, 1'b1, 1'b0);
    wb_valid = 1'b0;
    chk("s7_rst3_set", dut.u_rst.rst_q[3], 2'd1);
    chk("s7_rst10_clr", dut.u_rst.rst_q[10], 2'd0);

    // Asynchronous reset while waiting on a branch
    offer(2'd2, 5'd0, 5'd0, 5'd0, 1'b0, 32'h80);
    sb.push_back(exp_row(2'd2, 5'd0, 5'd0, 5'd0, 32'h80, 2'd0, 2'd0));
    cyc("s8_br_acc", 1'b0, 1'b1, 1'b0);
    offer(2'd0, 5'd11, 5'd0, 5'd0, 1'b1, 32'h81);
    cyc("s8_br_fire", 1'b1, 1'b1, 1'b0);
    fetch_valid = 1'b0;
    cyc("s8_wait", 1'b0, 1'b0, 1'b1);
    #2 nRST = 1'b0;
    #1;
    chk("s8_arst_bp", br_pending, 1'b0);
    chk("s8_arst_rdy", fetch_ready, 1'b1);
    chk("s8_arst_en", n_fust_s_en, 1'b0);
    chk("s8_arst_rst3", dut.u_rst.rst_q[3], 2'd0);
    @(posedge CLK); #1 nRST = 1'b1;
    cyc("s8_after", 1'b0, 1'b1, 1'b0);

    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
